crossbar_arbiter: RTL and testbench

Sequencing arbiter for the M-master / S-slave crossbar. It runs one independent round-robin arbiter per slave and drives the crossbar select vectors so each slave is owned by at most one master at a time. Ownership is held from grant until the selected transaction's final data handshake completes. The block sits beside the crossbar: it watches requests on the master side and handshakes on the slave side of the crossbar.

---
 rtl/crossbar_arbiter.sv | 169 ++++++++++++++++
 tb/tb_crossbar_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter.sv
// Per-slave round-robin ownership arbiter for an M-master / S-slave crossbar.
// Each slave runs an IDLE/ADDR/DATA sequencer; selects and grants are decoded from registers only.
module crossbar_arbiter #(
    parameter int M  = 3,
    parameter int S  = 2,
    parameter int MW = (M > 1) ? $clog2(M) : 1,
    parameter int SW = (S > 1) ? $clog2(S) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [M-1:0]    i_m_req,
    input  logic [M*SW-1:0] i_m_tgt,
    input  logic [S-1:0]    i_s_addr_val,
    input  logic [S-1:0]    i_s_addr_rdy,
    input  logic [S-1:0]    i_s_cmd_val,
    input  logic [S-1:0]    i_s_cmd_rdy,
    input  logic [S-1:0]    i_s_cmd,
    input  logic [S-1:0]    i_s_wr_val,
    input  logic [S-1:0]    i_s_wr_rdy,
    input  logic [S-1:0]    i_s_rd_val,
    input  logic [S-1:0]    i_s_rd_rdy,
    output logic [S*MW-1:0] o_m_sel_array,
    output logic [M*SW-1:0] o_s_sel_array,
    output logic [M-1:0]    o_m_gnt,
    output logic [S-1:0]    o_s_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    logic [S-1:0][MW-1:0] w_own;
    logic [S-1:0][MW-1:0] w_ptr;
    logic [S-1:0]         w_busy;
    logic [M-1:0]         w_gnt;
    logic [M-1:0][SW-1:0] w_ssel;
    logic [SW-1:0]        w_tgt [M];
    logic [S-1:0]         w_pick_val;
    logic [S-1:0][MW-1:0] w_pick_idx;
    logic [M-1:0]         w_taken;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_tgt
            assign w_tgt[gi] = i_m_tgt[gi*SW +: SW];
        end
    endgenerate

    // Round-robin search per slave; a master already owning a slave is not eligible.
    // Lower slave index wins a shared pick, the loser simply waits a cycle.
    always_comb begin
        logic [MW-1:0] cand;
        cand       = '0;
        w_taken    = '0;
        w_pick_val = '0;
        w_pick_idx = '0;
        for (int j = 0; j < S; j++) begin
            cand = w_ptr[j];
            for (int k = 0; k < M; k++) begin
                cand = (cand == MW'(M-1)) ? '0 : cand + 1'b1;
                if (!w_pick_val[j] && i_m_req[cand] && (w_tgt[cand] == SW'(j)) && !w_gnt[cand]) begin
                    w_pick_val[j] = 1'b1;
                    w_pick_idx[j] = cand;
                end
            end
            if (w_busy[j]) begin
                w_pick_val[j] = 1'b0;
            end else if (w_pick_val[j]) begin
                if (w_taken[w_pick_idx[j]]) w_pick_val[j] = 1'b0;
                else                        w_taken[w_pick_idx[j]] = 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < S; gi++) begin : g_slave
            state_t        r_state, w_state_next;
            logic [MW-1:0] r_own, w_own_next;
            logic [MW-1:0] r_ptr, w_ptr_next;
            logic          r_wr, w_wr_next;
            logic          r_addr_done, w_addr_done_next;
            logic          r_cmd_done, w_cmd_done_next;
            logic          w_addr_hs, w_cmd_hs, w_data_hs;

            assign w_addr_hs = i_s_addr_val[gi] & i_s_addr_rdy[gi];
            assign w_cmd_hs  = i_s_cmd_val[gi]  & i_s_cmd_rdy[gi];
            assign w_data_hs = r_wr ? (i_s_wr_val[gi] & i_s_wr_rdy[gi])
                                    : (i_s_rd_val[gi] & i_s_rd_rdy[gi]);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_state     <= ST_IDLE;
                    r_own       <= '0;
                    r_ptr       <= MW'(M-1);
                    r_wr        <= 1'b0;
                    r_addr_done <= 1'b0;
                    r_cmd_done  <= 1'b0;
                end else begin
                    r_state     <= w_state_next;
                    r_own       <= w_own_next;
                    r_ptr       <= w_ptr_next;
                    r_wr        <= w_wr_next;
                    r_addr_done <= w_addr_done_next;
                    r_cmd_done  <= w_cmd_done_next;
                end
            end

            always_comb begin
                w_state_next     = r_state;
                w_own_next       = r_own;
                w_ptr_next       = r_ptr;
                w_wr_next        = r_wr;
                w_addr_done_next = r_addr_done;
                w_cmd_done_next  = r_cmd_done;
                case (r_state)
                    ST_IDLE: begin
                        w_addr_done_next = 1'b0;
                        w_cmd_done_next  = 1'b0;
                        if (w_pick_val[gi]) begin
                            w_own_next   = w_pick_idx[gi];
                            w_ptr_next   = w_pick_idx[gi];
                            w_state_next = ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (w_cmd_hs && !r_cmd_done) w_wr_next = i_s_cmd[gi];
                        w_addr_done_next = r_addr_done | w_addr_hs;
                        w_cmd_done_next  = r_cmd_done | w_cmd_hs;
                        // Owner withdrew before its address was taken: give the slave back.
                        if (!i_m_req[r_own] && !r_addr_done && !w_addr_hs) begin
                            w_state_next     = ST_IDLE;
                            w_addr_done_next = 1'b0;
                            w_cmd_done_next  = 1'b0;
                        end else if ((r_addr_done | w_addr_hs) && (r_cmd_done | w_cmd_hs)) begin
                            w_state_next     = ST_DATA;
                            w_addr_done_next = 1'b0;
                            w_cmd_done_next  = 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (w_data_hs) w_state_next = ST_IDLE;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end

            assign w_busy[gi] = (r_state != ST_IDLE);
            assign w_own[gi]  = r_own;
            assign w_ptr[gi]  = r_ptr;
        end
    endgenerate

    always_comb begin
        w_gnt  = '0;
        w_ssel = '0;
        for (int j = 0; j < S; j++) begin
            for (int i = 0; i < M; i++) begin
                if (w_busy[j] && (w_own[j] == MW'(i))) begin
                    w_gnt[i]  = 1'b1;
                    w_ssel[i] = SW'(j);
                end
            end
        end
    end

    assign o_m_sel_array = w_own;
    assign o_s_sel_array = w_ssel;
    assign o_m_gnt       = w_gnt;
    assign o_s_busy      = w_busy;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Bench for crossbar_arbiter: directed scenarios with literal expectations, then a
// randomized run compared against a transaction-level ownership model.
module tb_crossbar_arbiter;
    localparam int M  = 3;
    localparam int S  = 2;
    localparam int MW = 2;
    localparam int SW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [M-1:0]    m_req = '0;
    logic [M*SW-1:0] m_tgt = '0;
    logic [S-1:0]    s_addr_val = '0, s_addr_rdy = '0, s_cmd_val = '0, s_cmd_rdy = '0, s_cmd = '0;
    logic [S-1:0]    s_wr_val = '0, s_wr_rdy = '0, s_rd_val = '0, s_rd_rdy = '0;
    logic [S*MW-1:0] m_sel_array;
    logic [M*SW-1:0] s_sel_array;
    logic [M-1:0]    m_gnt;
    logic [S-1:0]    s_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns each slave (-1 = free) and what the transaction has seen so far.
    int own_m [S];
    int last_own [S];
    int ptr_m [S];
    bit a_ok [S], c_ok [S], in_data [S], wr_m [S];

    crossbar_arbiter #(.M(M), .S(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_m_req(m_req), .i_m_tgt(m_tgt),
        .i_s_addr_val(s_addr_val), .i_s_addr_rdy(s_addr_rdy),
        .i_s_cmd_val(s_cmd_val), .i_s_cmd_rdy(s_cmd_rdy), .i_s_cmd(s_cmd),
        .i_s_wr_val(s_wr_val), .i_s_wr_rdy(s_wr_rdy),
        .i_s_rd_val(s_rd_val), .i_s_rd_rdy(s_rd_rdy),
        .o_m_sel_array(m_sel_array), .o_s_sel_array(s_sel_array),
        .o_m_gnt(m_gnt), .o_s_busy(s_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int j = 0; j < S; j++) begin
            own_m[j] = -1; last_own[j] = 0; ptr_m[j] = M-1;
            a_ok[j] = 0; c_ok[j] = 0; in_data[j] = 0; wr_m[j] = 0;
        end
    endtask

    task automatic model_step();
        bit owned [M];
        bit taken [M];
        int pick;
        int c;
        bit ahs, chs, dhs;
        for (int i = 0; i < M; i++) begin owned[i] = 0; taken[i] = 0; end
        for (int j = 0; j < S; j++) if (own_m[j] >= 0) owned[own_m[j]] = 1;
        for (int j = 0; j < S; j++) begin
            if (own_m[j] < 0) begin
                pick = -1;
                for (int k = 1; k <= M; k++) begin
                    c = (ptr_m[j] + k) % M;
                    if (pick < 0 && m_req[c] && int'(m_tgt[c]) == j && !owned[c]) pick = c;
                end
                if (pick >= 0 && !taken[pick]) begin
                    taken[pick] = 1;
                    own_m[j] = pick; last_own[j] = pick; ptr_m[j] = pick;
                    a_ok[j] = 0; c_ok[j] = 0; in_data[j] = 0;
                end
            end else if (!in_data[j]) begin
                ahs = s_addr_val[j] & s_addr_rdy[j];
                chs = s_cmd_val[j] & s_cmd_rdy[j];
                if (chs && !c_ok[j]) wr_m[j] = s_cmd[j];
                if (!m_req[own_m[j]] && !a_ok[j] && !ahs) begin
                    own_m[j] = -1;
                end else begin
                    a_ok[j] = a_ok[j] | ahs;
                    c_ok[j] = c_ok[j] | chs;
                    if (a_ok[j] && c_ok[j]) in_data[j] = 1;
                end
            end else begin
                dhs = wr_m[j] ? (s_wr_val[j] & s_wr_rdy[j]) : (s_rd_val[j] & s_rd_rdy[j]);
                if (dhs) begin own_m[j] = -1; in_data[j] = 0; end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_hs();
        s_addr_val = '0; s_addr_rdy = '0; s_cmd_val = '0; s_cmd_rdy = '0; s_cmd = '0;
        s_wr_val = '0; s_wr_rdy = '0; s_rd_val = '0; s_rd_rdy = '0;
    endtask

    task automatic hs_ac(input int j, input bit cmd);
        s_addr_val[j] = 1'b1; s_addr_rdy[j] = 1'b1;
        s_cmd_val[j]  = 1'b1; s_cmd_rdy[j]  = 1'b1; s_cmd[j] = cmd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_sel_array !== 4'b0000) begin errors++; $display("FAIL reset_msel: got %b expected 0000", m_sel_array); end
        checks++; if (s_sel_array !== 3'b000) begin errors++; $display("FAIL reset_ssel: got %b expected 000", s_sel_array); end
        checks++; if (m_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", m_gnt); end
        checks++; if (s_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", s_busy); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        m_req = 3'b001; m_tgt = 3'b001;
        tick();
        checks++; if (m_gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b expected 001", m_gnt); end
        checks++; if (s_sel_array !== 3'b001) begin errors++; $display("FAIL single_ssel: got %b expected 001", s_sel_array); end
        checks++; if (m_sel_array[3:2] !== 2'd0) begin errors++; $display("FAIL single_msel1: got %0d expected 0", m_sel_array[3:2]); end
        checks++; if (s_busy !== 2'b10) begin errors++; $display("FAIL single_busy: got %b expected 10", s_busy); end
        hs_ac(1, 1'b0);
        tick();
        clr_hs();
        checks++; if (s_busy !== 2'b10) begin errors++; $display("FAIL single_data_busy: got %b expected 10", s_busy); end
        s_rd_val = 2'b10; s_rd_rdy = 2'b10; m_req = 3'b000;
        tick();
        clr_hs();
        checks++; if (s_busy !== 2'b00) begin errors++; $display("FAIL single_release: got %b expected 00", s_busy); end
        $display("single read transaction on slave 1 done");
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 2, 0};
        m_req = 3'b111; m_tgt = 3'b000;
        for (int t = 0; t < 4; t++) begin
            clr_hs();
            tick();
            checks++; if (m_gnt !== 3'(1 << order[t])) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", t, m_gnt, 3'(1 << order[t])); end
            checks++; if (m_sel_array[1:0] !== 2'(order[t])) begin errors++; $display("FAIL rr_msel%0d: got %0d expected %0d", t, m_sel_array[1:0], order[t]); end
            hs_ac(0, 1'b1);
            tick();
            clr_hs();
            s_wr_val = 2'b01; s_wr_rdy = 2'b01;
            tick();
            clr_hs();
            checks++; if (m_gnt !== 3'b000 || s_busy !== 2'b00) begin errors++; $display("FAIL rr_gap%0d: got gnt %b busy %b expected 000 00", t, m_gnt, s_busy); end
            $display("round robin write transaction by master %0d", order[t]);
        end
        m_req = 3'b000;
    endtask

    task automatic test_parallel();
        m_req = 3'b101; m_tgt = 3'b100;
        tick();
        checks++; if (m_gnt !== 3'b101) begin errors++; $display("FAIL par_gnt: got %b expected 101", m_gnt); end
        checks++; if (s_sel_array !== 3'b100) begin errors++; $display("FAIL par_ssel: got %b expected 100", s_sel_array); end
        checks++; if (m_sel_array !== 4'b1000) begin errors++; $display("FAIL par_msel: got %b expected 1000", m_sel_array); end
        checks++; if (s_busy !== 2'b11) begin errors++; $display("FAIL par_busy: got %b expected 11", s_busy); end
        hs_ac(0, 1'b0); hs_ac(1, 1'b0);
        tick();
        clr_hs();
        s_rd_val = 2'b11; s_rd_rdy = 2'b11; m_req = 3'b000;
        tick();
        clr_hs();
        checks++; if (s_busy !== 2'b00) begin errors++; $display("FAIL par_release: got %b expected 00", s_busy); end
        $display("parallel reads by masters 0 and 2 done");
    endtask

    task automatic test_hs_order();
        m_req = 3'b010; m_tgt = 3'b000;
        tick();
        checks++; if (m_gnt !== 3'b010) begin errors++; $display("FAIL ord_gnt: got %b expected 010", m_gnt); end
        s_cmd_val = 2'b01; s_cmd_rdy = 2'b01; s_cmd = 2'b01;
        tick();
        clr_hs();
        s_wr_val = 2'b01; s_wr_rdy = 2'b01;
        for (int w = 0; w < 2; w++) begin
            tick();
            checks++; if (s_busy[0] !== 1'b1) begin errors++; $display("FAIL ord_wait%0d: got busy %b expected 1", w, s_busy[0]); end
        end
        clr_hs();
        s_addr_val = 2'b01; s_addr_rdy = 2'b01;
        tick();
        clr_hs();
        s_rd_val = 2'b01; s_rd_rdy = 2'b01;
        tick();
        clr_hs();
        checks++; if (s_busy[0] !== 1'b1) begin errors++; $display("FAIL ord_rd_ignored: got busy %b expected 1", s_busy[0]); end
        s_wr_val = 2'b01; s_wr_rdy = 2'b01; m_req = 3'b000;
        tick();
        clr_hs();
        checks++; if (s_busy[0] !== 1'b0 || m_gnt !== 3'b000) begin errors++; $display("FAIL ord_wr_release: got busy %b gnt %b expected 0 000", s_busy[0], m_gnt); end
        $display("out-of-order write transaction by master 1 done");
    endtask

    task automatic test_abort();
        m_req = 3'b010; m_tgt = 3'b000;
        tick();
        checks++; if (m_gnt !== 3'b010) begin errors++; $display("FAIL abort_gnt: got %b expected 010", m_gnt); end
        m_req = 3'b000;
        tick();
        checks++; if (m_gnt !== 3'b000 || s_busy !== 2'b00) begin errors++; $display("FAIL abort_drop: got gnt %b busy %b expected 000 00", m_gnt, s_busy); end
        m_req = 3'b111;
        tick();
        checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL abort_next: got %b expected 100", m_gnt); end
        m_req = 3'b000;
        tick();
        $display("abort by master 1 done");
    endtask

    task automatic test_reset_mid();
        m_req = 3'b001; m_tgt = 3'b000;
        tick();
        hs_ac(0, 1'b1);
        tick();
        clr_hs();
        checks++; if (s_busy !== 2'b01) begin errors++; $display("FAIL rmid_busy: got %b expected 01", s_busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (m_gnt !== 3'b000 || s_busy !== 2'b00) begin errors++; $display("FAIL rmid_async: got gnt %b busy %b expected 000 00", m_gnt, s_busy); end
        checks++; if (m_sel_array !== 4'b0000 || s_sel_array !== 3'b000) begin errors++; $display("FAIL rmid_sel: got msel %b ssel %b expected 0000 000", m_sel_array, s_sel_array); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        m_req = 3'b111;
        tick();
        checks++; if (m_gnt !== 3'b001) begin errors++; $display("FAIL rmid_priority: got %b expected 001", m_gnt); end
        m_req = 3'b000;
        tick();
        $display("reset during data phase done");
    endtask

    task automatic test_random();
        logic [M-1:0]    exp_gnt;
        logic [M*SW-1:0] exp_ssel;
        logic [S-1:0]    exp_busy;
        logic [S*MW-1:0] exp_msel;
        int errs_before;
        errs_before = errors;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < M; i++) m_req[i] = ($urandom_range(0, 9) < 8);
            m_tgt      = 3'($urandom);
            s_addr_val = 2'($urandom); s_addr_rdy = 2'($urandom);
            s_cmd_val  = 2'($urandom); s_cmd_rdy  = 2'($urandom); s_cmd = 2'($urandom);
            s_wr_val   = 2'($urandom); s_wr_rdy   = 2'($urandom);
            s_rd_val   = 2'($urandom); s_rd_rdy   = 2'($urandom);
            tick();
            exp_gnt = '0; exp_ssel = '0; exp_busy = '0; exp_msel = '0;
            for (int j = 0; j < S; j++) begin
                exp_msel[j*MW +: MW] = MW'(last_own[j]);
                if (own_m[j] >= 0) begin
                    exp_busy[j] = 1'b1;
                    exp_gnt[own_m[j]] = 1'b1;
                    exp_ssel[own_m[j]] = SW'(j);
                end
            end
            checks++; if (m_gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt cycle %0d: got %b expected %b", n, m_gnt, exp_gnt); end
            checks++; if (s_busy !== exp_busy) begin errors++; $display("FAIL rand_busy cycle %0d: got %b expected %b", n, s_busy, exp_busy); end
            checks++; if (s_sel_array !== exp_ssel) begin errors++; $display("FAIL rand_ssel cycle %0d: got %b expected %b", n, s_sel_array, exp_ssel); end
            checks++; if (m_sel_array !== exp_msel) begin errors++; $display("FAIL rand_msel cycle %0d: got %b expected %b", n, m_sel_array, exp_msel); end
        end
        clr_hs();
        m_req = '0;
        $display("random run of 500 cycles done with %0d new errors", errors - errs_before);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_parallel();
        test_hs_order();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
